mem_port_arbiter: RTL and testbench

- Shares the core's single unified memory port between two requesters.
  - Port 0: the multicycle core's fetch/load/store address path.
  - Port 1: the program loader / debug access path, used while the core is halted or on EBreak.
- Serialises accesses, arbitrates round-robin, issues one memory access at a time with a fixed latency, and returns a one-cycle ack with the read data.
- Sits between the core/loader and the memory model.

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter onto one fixed-latency memory port, one access in flight at a time.
// Defining MEM_ARB_PERF_CNT_EN adds per-port grant counters and a contention counter.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_ack,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_ack,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]         m0_grant_cnt,
  output logic [31:0]         m1_grant_cnt,
  output logic [31:0]         contend_cnt
`endif
);

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_wait_cnt;
  logic                r_last_grant;
  logic                r_grant;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W/8-1:0] r_mem_wstrb;
  logic [DATA_W-1:0]   r_m0_rdata;
  logic [DATA_W-1:0]   r_m1_rdata;
  logic                w_grant_vld;
  logic                w_grant_port;
  logic                w_rd_resp;

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_vld  = 1'b0;
    w_grant_port = 1'b0;
    case (r_state)
      IDLE: begin
        if (m0_req && m1_req) begin
          w_grant_vld  = 1'b1;
          w_grant_port = ~r_last_grant;
        end else if (m0_req || m1_req) begin
          w_grant_vld  = 1'b1;
          w_grant_port = m1_req;
        end
        if (w_grant_vld) w_state_nxt = ACCESS;
      end
      ACCESS:  w_state_nxt = (LAT_M1 != 4'd0) ? WAIT : RESP;
      WAIT:    if (r_wait_cnt == 4'd1) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_wait_cnt   <= 4'd0;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wstrb  <= '0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Payload is captured once at grant; requester changes afterwards are ignored.
      if (r_state == IDLE && w_grant_vld) begin
        r_grant      <= w_grant_port;
        r_last_grant <= w_grant_port;
        r_mem_we     <= w_grant_port ? m1_we    : m0_we;
        r_mem_addr   <= w_grant_port ? m1_addr  : m0_addr;
        r_mem_wdata  <= w_grant_port ? m1_wdata : m0_wdata;
        r_mem_wstrb  <= w_grant_port ? m1_wstrb : m0_wstrb;
      end
      if (r_state == ACCESS) r_wait_cnt <= LAT_M1;
      else if (r_state == WAIT) r_wait_cnt <= r_wait_cnt - 4'd1;
      if (w_rd_resp && !r_grant) r_m0_rdata <= mem_rdata;
      if (w_rd_resp && r_grant)  r_m1_rdata <= mem_rdata;
    end
  end

  assign w_rd_resp = (r_state == RESP) && !r_mem_we;

  // Read data bypasses the holding register during the ack cycle so it is valid with ack.
  assign m0_ack    = (r_state == RESP) && !r_grant;
  assign m1_ack    = (r_state == RESP) && r_grant;
  assign m0_rdata  = (w_rd_resp && !r_grant) ? mem_rdata : r_m0_rdata;
  assign m1_rdata  = (w_rd_resp && r_grant)  ? mem_rdata : r_m1_rdata;
  assign mem_en    = (r_state == ACCESS);
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign busy      = (r_state != IDLE);

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] r_m0_grant_cnt;
  logic [31:0] r_m1_grant_cnt;
  logic [31:0] r_contend_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_m0_grant_cnt <= 32'd0;
      r_m1_grant_cnt <= 32'd0;
      r_contend_cnt  <= 32'd0;
    end else begin
      if (r_state == IDLE && w_grant_vld && !w_grant_port) r_m0_grant_cnt <= r_m0_grant_cnt + 32'd1;
      if (r_state == IDLE && w_grant_vld && w_grant_port)  r_m1_grant_cnt <= r_m1_grant_cnt + 32'd1;
      if (r_state == IDLE && m0_req && m1_req)             r_contend_cnt  <= r_contend_cnt + 32'd1;
    end
  end

  assign m0_grant_cnt = r_m0_grant_cnt;
  assign m1_grant_cnt = r_m1_grant_cnt;
  assign contend_cnt  = r_contend_cnt;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance at latency 1, one at latency 3, each with its own memory model.
// Honours MEM_ARB_PERF_CNT_EN when defined.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  int n_checks = 0;
  int n_fail   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic [SW-1:0] m0_wstrb = '0, m1_wstrb = '0;

  logic          a_m0_ack, a_m1_ack, a_mem_en, a_mem_we, a_busy;
  logic [DW-1:0] a_m0_rdata, a_m1_rdata, a_mem_wdata, a_mem_rdata;
  logic [AW-1:0] a_mem_addr;
  logic [SW-1:0] a_mem_wstrb;
  logic          b_m0_ack, b_m1_ack, b_mem_en, b_mem_we, b_busy;
  logic [DW-1:0] b_m0_rdata, b_m1_rdata, b_mem_wdata, b_mem_rdata;
  logic [AW-1:0] b_mem_addr;
  logic [SW-1:0] b_mem_wstrb;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0]   a_m0_gcnt, a_m1_gcnt, a_ccnt, b_m0_gcnt, b_m1_gcnt, b_ccnt;
`endif

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ack(a_m0_ack), .m0_rdata(a_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ack(a_m1_ack), .m1_rdata(a_m1_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_wstrb(a_mem_wstrb), .mem_rdata(a_mem_rdata), .busy(a_busy)
`ifdef MEM_ARB_PERF_CNT_EN
    , .m0_grant_cnt(a_m0_gcnt), .m1_grant_cnt(a_m1_gcnt), .contend_cnt(a_ccnt)
`endif
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(3)) u_lat3 (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_wstrb(b_mem_wstrb), .mem_rdata(b_mem_rdata), .busy(b_busy)
`ifdef MEM_ARB_PERF_CNT_EN
    , .m0_grant_cnt(b_m0_gcnt), .m1_grant_cnt(b_m1_gcnt), .contend_cnt(b_ccnt)
`endif
  );

  // Memory models: 256 words indexed by addr[9:2], read data appears MEM_LATENCY cycles after mem_en.
  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  logic [31:0] a_pipe;
  logic [31:0] b_pipe [0:2];
  logic        pl_a = 1'b0, pl_b = 1'b0;
  logic [7:0]  pl_idx = 8'd0;
  logic [31:0] pl_dat = 32'd0;

  function automatic logic [31:0] init_word(input int i);
    return 32'h5A5A_0000 ^ (32'(i) * 32'h0101_0103);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= init_word(i);
    end else begin
      if (pl_a) mem_a[pl_idx] <= pl_dat;
      if (a_mem_en && a_mem_we)
        for (int k = 0; k < SW; k++)
          if (a_mem_wstrb[k]) mem_a[a_mem_addr[9:2]][8*k +: 8] <= a_mem_wdata[8*k +: 8];
    end
    a_pipe <= a_mem_en ? mem_a[a_mem_addr[9:2]] : 32'd0;
  end
  assign a_mem_rdata = a_pipe;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= init_word(i);
    end else begin
      if (pl_b) mem_b[pl_idx] <= pl_dat;
      if (b_mem_en && b_mem_we)
        for (int k = 0; k < SW; k++)
          if (b_mem_wstrb[k]) mem_b[b_mem_addr[9:2]][8*k +: 8] <= b_mem_wdata[8*k +: 8];
    end
    b_pipe[0] <= b_mem_en ? mem_b[b_mem_addr[9:2]] : 32'd0;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign b_mem_rdata = b_pipe[2];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic poke(input bit to_b, input int idx, input logic [31:0] d);
    pl_a = !to_b; pl_b = to_b; pl_idx = 8'(idx); pl_dat = d;
    tick();
    pl_a = 1'b0; pl_b = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) tick();
    n_checks++;
    if ({a_m0_ack, a_m1_ack, a_mem_en, a_mem_we, a_busy, b_m0_ack, b_m1_ack, b_mem_en, b_mem_we, b_busy} !== 10'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got a=%b%b%b%b%b b=%b%b%b%b%b want all 0", a_m0_ack, a_m1_ack,
                         a_mem_en, a_mem_we, a_busy, b_m0_ack, b_m1_ack, b_mem_en, b_mem_we, b_busy);
    end
    n_checks++;
    if ({a_mem_addr, a_mem_wdata, a_mem_wstrb, b_mem_addr, b_mem_wdata, b_mem_wstrb} !== '0) begin
      n_fail++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h wstrb=%h want 0", a_mem_addr, a_mem_wdata, a_mem_wstrb);
    end
    n_checks++;
    if ({a_m0_rdata, a_m1_rdata, b_m0_rdata, b_m1_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_rdata: got %h %h %h %h want 0", a_m0_rdata, a_m1_rdata, b_m0_rdata, b_m1_rdata);
    end
  endtask

  task automatic test_read_l1();
    do_reset();
    poke(1'b0, 64, 32'hDEADBEEF);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
    tick();
    n_checks++;
    if ({a_mem_en, a_mem_we, a_mem_addr, a_m0_ack, a_busy} !== {1'b1, 1'b0, 32'h100, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL read_access: got en=%b we=%b addr=%h ack=%b busy=%b want 1 0 100 0 1",
                         a_mem_en, a_mem_we, a_mem_addr, a_m0_ack, a_busy);
    end
    tick();
    n_checks++;
    if ({a_m0_ack, a_m1_ack, a_mem_en, a_m0_rdata} !== {3'b100, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL read_ack: got ack0=%b ack1=%b en=%b rdata=%h want 1 0 0 deadbeef",
                         a_m0_ack, a_m1_ack, a_mem_en, a_m0_rdata);
    end
    m0_req = 1'b0;
    tick();
    n_checks++;
    if ({a_busy, a_m0_ack, a_m0_rdata} !== {2'b00, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL read_after: got busy=%b ack=%b rdata=%h want 0 0 deadbeef", a_busy, a_m0_ack, a_m0_rdata);
    end
  endtask

  task automatic test_write_l1();
    int en_cnt, ack_cnt;
    logic [31:0] got_addr, got_wdata, got_rdata;
    logic got_we, bad_ack0;
    logic [3:0] got_strb;
    do_reset();
    poke(1'b0, 128, 32'hFFFFFFFF);
    en_cnt = 0; ack_cnt = 0; bad_ack0 = 1'b0;
    got_addr = '0; got_wdata = '0; got_rdata = '0; got_we = 1'b0; got_strb = '0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h200; m1_wdata = 32'h12345678; m1_wstrb = 4'h3;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (a_mem_en) begin
        en_cnt++; got_we = a_mem_we; got_addr = a_mem_addr; got_wdata = a_mem_wdata; got_strb = a_mem_wstrb;
      end
      if (a_m0_ack) bad_ack0 = 1'b1;
      if (a_m1_ack) begin ack_cnt++; got_rdata = a_m1_rdata; m1_req = 1'b0; end
    end
    n_checks++;
    if (en_cnt != 1 || ack_cnt != 1 || bad_ack0) begin
      n_fail++; $display("FAIL write_counts: got mem_en=%0d m1_ack=%0d m0_ack_seen=%b want 1 1 0", en_cnt, ack_cnt, bad_ack0);
    end
    n_checks++;
    if ({got_we, got_addr, got_wdata, got_strb} !== {1'b1, 32'h200, 32'h12345678, 4'h3}) begin
      n_fail++; $display("FAIL write_payload: got we=%b addr=%h data=%h strb=%h want 1 200 12345678 3",
                         got_we, got_addr, got_wdata, got_strb);
    end
    n_checks++;
    if (got_rdata !== 32'h0 || a_m1_rdata !== 32'h0) begin
      n_fail++; $display("FAIL write_rdata: got %h/%h want 00000000 (unchanged)", got_rdata, a_m1_rdata);
    end
    n_checks++;
    if (mem_a[128] !== 32'hFFFF5678) begin
      n_fail++; $display("FAIL write_mem: got %h want ffff5678", mem_a[128]);
    end
  endtask

  task automatic test_contention();
    int c0, c1;
    logic both;
    int order[$];
    do_reset();
    c0 = 0; c1 = 0; both = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h010; m1_req = 1'b1; m1_addr = 32'h020;
    for (int t = 0; t < 80 && (c0 < 4 || c1 < 4); t++) begin
      tick();
      if (a_m0_ack && a_m1_ack) both = 1'b1;
      if (a_m0_ack) begin
        order.push_back(0); c0++;
        if (c0 < 4) m0_addr = m0_addr + 32'd4; else m0_req = 1'b0;
      end
      if (a_m1_ack) begin
        order.push_back(1); c1++;
        if (c1 < 4) m1_addr = m1_addr + 32'd4; else m1_req = 1'b0;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    n_checks++;
    if (both) begin n_fail++; $display("FAIL contend_dual_ack: got both acks in one cycle want never"); end
    n_checks++;
    if (order.size() != 8) begin n_fail++; $display("FAIL contend_count: got %0d acks want 8", order.size()); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (i >= order.size()) begin
        n_fail++; $display("FAIL contend_order[%0d]: got none want %0d", i, i % 2);
      end else if (order[i] != i % 2) begin
        n_fail++; $display("FAIL contend_order[%0d]: got %0d want %0d", i, order[i], i % 2);
      end
    end
  endtask

  task automatic test_latency3();
    int en_t, ack_t, en_n;
    logic addr_ok;
    logic [31:0] rd;
    do_reset();
    poke(1'b1, 192, 32'hA5A50003);
    en_t = -1; ack_t = -1; en_n = 0; addr_ok = 1'b1; rd = '0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h300;
    for (int t = 1; t <= 12 && ack_t < 0; t++) begin
      tick();
      if (b_mem_en) begin en_n++; if (en_t < 0) en_t = t; end
      if (en_t >= 0 && b_mem_addr !== 32'h300) addr_ok = 1'b0;
      if (b_m0_ack) begin ack_t = t; rd = b_m0_rdata; m0_req = 1'b0; end
      if (t == 2) m0_addr = 32'h3FC;
    end
    m0_req = 1'b0;
    n_checks++;
    if (en_t != 1 || en_n != 1) begin
      n_fail++; $display("FAIL lat3_en: got first at %0d count %0d want at 1 count 1", en_t, en_n);
    end
    n_checks++;
    if (ack_t - en_t != 3) begin
      n_fail++; $display("FAIL lat3_ack: got ack %0d cycles after mem_en want 3", ack_t - en_t);
    end
    n_checks++;
    if (rd !== 32'hA5A50003) begin n_fail++; $display("FAIL lat3_rdata: got %h want a5a50003", rd); end
    n_checks++;
    if (!addr_ok) begin n_fail++; $display("FAIL lat3_addr_hold: got mem_addr changed want 00000300 held"); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    do_reset();
    seen = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h040;
    for (int t = 0; t < 12 && !seen; t++) begin
      tick();
      if (b_m0_ack) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL midrst_first_ack: got no ack want ack"); end
    m0_addr = 32'h044;
    tick();
    tick();
    n_checks++;
    if ({b_mem_en, b_mem_addr} !== {1'b1, 32'h044}) begin
      n_fail++; $display("FAIL midrst_access: got en=%b addr=%h want 1 044", b_mem_en, b_mem_addr);
    end
    tick();
    n_checks++;
    if ({b_busy, b_mem_en} !== 2'b10) begin
      n_fail++; $display("FAIL midrst_wait: got busy=%b en=%b want 1 0", b_busy, b_mem_en);
    end
    reset = 1'b1; m0_req = 1'b0;
    tick();
    n_checks++;
    if ({b_busy, b_mem_en, b_m0_ack, b_m1_ack} !== 4'b0000) begin
      n_fail++; $display("FAIL midrst_idle: got busy=%b en=%b ack0=%b ack1=%b want 0 0 0 0",
                         b_busy, b_mem_en, b_m0_ack, b_m1_ack);
    end
    reset = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h080; m1_req = 1'b1; m1_addr = 32'h0C0;
    tick();
    n_checks++;
    if ({b_mem_en, b_mem_addr, b_m0_ack, b_m1_ack} !== {1'b1, 32'h080, 2'b00}) begin
      n_fail++; $display("FAIL midrst_regrant: got en=%b addr=%h ack0=%b ack1=%b want 1 080 0 0",
                         b_mem_en, b_mem_addr, b_m0_ack, b_m1_ack);
    end
    clear_inputs();
  endtask

  // Transaction-level model: an IDLE arbiter grants at cycle g, mem_en at g+1, ack at g+1+L, IDLE again at g+L+2.
  task automatic test_random();
    localparam int L = 1;
    logic [31:0] sh [0:255];
    logic [31:0] prd [0:1];
    logic        rq [0:1];
    logic        pw [0:1];
    logic [31:0] pa [0:1];
    logic [31:0] pd [0:1];
    logic [3:0]  ps [0:1];
    logic        done [0:1];
    logic        evld, ewe, exp_en, exp_busy;
    logic [1:0]  exp_ack;
    logic [31:0] eaddr, ewdata, erd, exp_rd, act_rd;
    logic [3:0]  estrb;
    logic [7:0]  idx;
    int free_at, last, gcyc, eport, gp;
    do_reset();
    for (int i = 0; i < 256; i++) sh[i] = init_word(i);
    for (int p = 0; p < 2; p++) begin
      prd[p] = '0; rq[p] = 1'b0; pw[p] = 1'b0; pa[p] = '0; pd[p] = '0; ps[p] = '0; done[p] = 1'b0;
    end
    evld = 1'b0; ewe = 1'b0; eaddr = '0; ewdata = '0; erd = '0; estrb = '0;
    free_at = 0; last = 1; gcyc = 0; eport = 0;
    for (int c = 0; c < 2000; c++) begin
      done[0] = 1'b0; done[1] = 1'b0;
      exp_ack  = {evld && c == gcyc + 1 + L && eport == 1, evld && c == gcyc + 1 + L && eport == 0};
      exp_en   = evld && c == gcyc + 1;
      exp_busy = evld && c >= gcyc + 1 && c <= gcyc + 1 + L;
      n_checks++;
      if ({a_m1_ack, a_m0_ack} !== exp_ack) begin
        n_fail++; $display("FAIL rand_ack c=%0d: got m1/m0=%b%b want %b", c, a_m1_ack, a_m0_ack, exp_ack);
      end
      n_checks++;
      if ({a_mem_en, a_busy} !== {exp_en, exp_busy}) begin
        n_fail++; $display("FAIL rand_en_busy c=%0d: got en=%b busy=%b want %b %b", c, a_mem_en, a_busy, exp_en, exp_busy);
      end
      if (exp_en) begin
        n_checks++;
        if ({a_mem_we, a_mem_addr, a_mem_wdata, a_mem_wstrb} !== {ewe, eaddr, ewdata, estrb}) begin
          n_fail++; $display("FAIL rand_payload c=%0d: got %b %h %h %h want %b %h %h %h", c, a_mem_we, a_mem_addr,
                             a_mem_wdata, a_mem_wstrb, ewe, eaddr, ewdata, estrb);
        end
      end
      if (exp_ack != 2'b00) begin
        act_rd = (eport == 1) ? a_m1_rdata : a_m0_rdata;
        exp_rd = ewe ? prd[eport] : erd;
        n_checks++;
        if (act_rd !== exp_rd) begin
          n_fail++; $display("FAIL rand_rdata c=%0d port %0d: got %h want %h", c, eport, act_rd, exp_rd);
        end
        prd[eport] = exp_rd;
        done[eport] = 1'b1;
      end
      for (int p = 0; p < 2; p++) begin
        if (rq[p] && done[p]) rq[p] = 1'b0;
        if (!rq[p] && $urandom_range(0, 2) != 0) begin
          rq[p] = 1'b1;
          pw[p] = 1'($urandom_range(0, 1));
          pa[p] = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
          pd[p] = $urandom;
          ps[p] = 4'($urandom_range(0, 15));
        end
      end
      m0_req = rq[0]; m0_we = pw[0]; m0_addr = pa[0]; m0_wdata = pd[0]; m0_wstrb = ps[0];
      m1_req = rq[1]; m1_we = pw[1]; m1_addr = pa[1]; m1_wdata = pd[1]; m1_wstrb = ps[1];
      if (c >= free_at && (rq[0] || rq[1])) begin
        gp = (rq[0] && rq[1]) ? 1 - last : (rq[0] ? 0 : 1);
        last = gp; eport = gp; gcyc = c; free_at = c + L + 2; evld = 1'b1;
        ewe = pw[gp]; eaddr = pa[gp]; ewdata = pd[gp]; estrb = ps[gp];
        idx = eaddr[9:2];
        erd = sh[idx];
        if (ewe)
          for (int k = 0; k < SW; k++) if (estrb[k]) sh[idx][8*k +: 8] = ewdata[8*k +: 8];
      end
      tick();
    end
    clear_inputs();
  endtask

`ifdef MEM_ARB_PERF_CNT_EN
  task automatic test_perf_cnt();
    logic got0, got1, got;
    do_reset();
    got0 = 1'b0; got1 = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h010; m1_req = 1'b1; m1_addr = 32'h020;
    for (int t = 0; t < 40 && !(got0 && got1); t++) begin
      tick();
      if (a_m0_ack) begin got0 = 1'b1; m0_req = 1'b0; end
      if (a_m1_ack) begin got1 = 1'b1; m1_req = 1'b0; end
    end
    for (int j = 0; j < 3; j++) begin
      if (j < 2) m0_req = 1'b1; else m1_req = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin
        tick();
        if (a_m0_ack || a_m1_ack) begin got = 1'b1; m0_req = 1'b0; m1_req = 1'b0; end
      end
    end
    tick();
    n_checks++;
    if (a_m0_gcnt !== 32'd3) begin n_fail++; $display("FAIL perf_m0_grants: got %0d want 3", a_m0_gcnt); end
    n_checks++;
    if (a_m1_gcnt !== 32'd2) begin n_fail++; $display("FAIL perf_m1_grants: got %0d want 2", a_m1_gcnt); end
    n_checks++;
    if (a_ccnt !== 32'd1) begin n_fail++; $display("FAIL perf_contend: got %0d want 1", a_ccnt); end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_l1();
    test_write_l1();
    test_contention();
    test_latency3();
    test_reset_mid();
    test_random();
`ifdef MEM_ARB_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
